ex_ctrl_decode: RTL and testbench

// - Drives the control interface of the execute-stage ALU/shifter: decodes the ID-stage instruction, registers its

---
 rtl/ex_ctrl_decode.sv | 183 ++++++++++++++++++
 tb/tb_ex_ctrl_decode.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/ex_ctrl_decode.sv
// ID/EX control decode for the execute-stage ALU/shifter, with flag register and RUN/HALTED control.
// Optional build macro FLAG_BYPASS_EN forwards the incoming ALU flags onto flag_n/v/z in the same cycle.
module ex_ctrl_decode #(
  parameter logic [2:0] FLAG_RESET = 3'b000,
  parameter int         SHF_SETS_Z = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] id_instr,
  input  logic        id_valid,
  input  logic        stall,
  input  logic        flush,
  input  logic        alu_n,
  input  logic        alu_v,
  input  logic        alu_z,
  output logic [1:0]  ex_alu_src,
  output logic [2:0]  ex_alu_op,
  output logic [1:0]  ex_shf_op,
  output logic        ex_llb,
  output logic        ex_lhb,
  output logic        ex_as,
  output logic [7:0]  ex_instr8,
  output logic [2:0]  ex_flag_wr,
  output logic        ex_valid,
  output logic        flag_n,
  output logic        flag_v,
  output logic        flag_z,
  output logic        halted
);

  typedef enum logic [0:0] {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_t;

  typedef struct packed {
    logic [1:0] src;
    logic [2:0] op;
    logic [1:0] shf;
    logic       llb;
    logic       lhb;
    logic       as_sel;
    logic [7:0] instr8;
    logic [2:0] flag_wr;
  } ctrl_t;

  localparam logic [2:0] SHF_MASK = (SHF_SETS_Z != 0) ? 3'b001 : 3'b000;

  state_t     state_r;
  logic       halted_r;
  ctrl_t      ex_r;
  logic       ex_valid_r;
  logic [2:0] flags_r;
  ctrl_t      decode_s;
  ctrl_t      load_ctrl_s;
  logic       load_valid_s;
  logic       is_hlt_s;
  logic       flag_upd_en_s;
  logic [2:0] flags_upd_s;
  logic [2:0] flag_out_s;

  // Opcode to control decode of the ID-stage instruction
  always_comb begin
    decode_s        = '0;
    decode_s.instr8 = id_instr[7:0];
    case (id_instr[15:12])
      4'h0: begin decode_s.src = 2'd1; decode_s.op = 3'b000; decode_s.flag_wr = 3'b111; end
      4'h1: begin decode_s.src = 2'd1; decode_s.op = 3'b001; decode_s.flag_wr = 3'b111; end
      4'h2: begin decode_s.src = 2'd1; decode_s.op = 3'b010; decode_s.flag_wr = 3'b111; end
      4'h3: begin decode_s.src = 2'd1; decode_s.op = 3'b011; decode_s.flag_wr = 3'b001; end
      4'h4: begin decode_s.src = 2'd1; decode_s.op = 3'b100; decode_s.flag_wr = 3'b001; end
      4'h5: begin decode_s.as_sel = 1'b1; decode_s.shf = 2'b00; decode_s.flag_wr = SHF_MASK; end
      4'h6: begin decode_s.as_sel = 1'b1; decode_s.shf = 2'b11; decode_s.flag_wr = SHF_MASK; end
      4'h7: begin decode_s.as_sel = 1'b1; decode_s.shf = 2'b01; decode_s.flag_wr = SHF_MASK; end
      4'h8: begin decode_s.src = 2'd2; end
      4'h9: begin decode_s.src = 2'd2; end
      4'hA: begin decode_s.lhb = 1'b1; end
      4'hB: begin decode_s.as_sel = 1'b1; decode_s.llb = 1'b1; end
      default: begin decode_s.src = 2'd0; end
    endcase
  end

  // Select decoded controls or a bubble for the next ID/EX load
  always_comb begin
    is_hlt_s = (id_instr[15:12] == 4'hF);
    if (id_valid && (state_r == ST_RUN)) begin
      load_ctrl_s  = decode_s;
      load_valid_s = 1'b1;
    end else begin
      load_ctrl_s  = '0;
      load_valid_s = 1'b0;
    end
  end

  // ID/EX pipeline register: reset > flush > stall > load
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_r       <= '0;
      ex_valid_r <= 1'b0;
    end else if (flush) begin
      ex_r       <= '0;
      ex_valid_r <= 1'b0;
    end else if (stall) begin
      ex_r       <= ex_r;
      ex_valid_r <= ex_valid_r;
    end else begin
      ex_r       <= load_ctrl_s;
      ex_valid_r <= load_valid_s;
    end
  end

  // RUN/HALTED state machine; HALTED is left only through reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r  <= ST_RUN;
      halted_r <= 1'b0;
    end else begin
      case (state_r)
        ST_RUN: begin
          if (!flush && !stall && id_valid && is_hlt_s) begin
            state_r  <= ST_HALTED;
            halted_r <= 1'b1;
          end else begin
            state_r  <= ST_RUN;
            halted_r <= 1'b0;
          end
        end
        ST_HALTED: begin
          state_r  <= ST_HALTED;
          halted_r <= 1'b1;
        end
        default: begin
          state_r  <= ST_RUN;
          halted_r <= 1'b0;
        end
      endcase
    end
  end

  // Masked merge of returned ALU flags; flush does not gate the EX-side update
  always_comb begin
    flag_upd_en_s = ex_valid_r && !stall;
    flags_upd_s   = (flags_r & ~ex_r.flag_wr) | ({alu_n, alu_v, alu_z} & ex_r.flag_wr);
  end

  // Architectural flag register {N,V,Z}
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      flags_r <= FLAG_RESET;
    end else if (flag_upd_en_s) begin
      flags_r <= flags_upd_s;
    end else begin
      flags_r <= flags_r;
    end
  end

  // Flag output view, optionally forwarding the in-flight update
  always_comb begin
    flag_out_s = flags_r;
`ifdef FLAG_BYPASS_EN
    if (flag_upd_en_s) begin
      flag_out_s = flags_upd_s;
    end else begin
      flag_out_s = flags_r;
    end
`endif
  end

  assign ex_alu_src = ex_r.src;
  assign ex_alu_op  = ex_r.op;
  assign ex_shf_op  = ex_r.shf;
  assign ex_llb     = ex_r.llb;
  assign ex_lhb     = ex_r.lhb;
  assign ex_as      = ex_r.as_sel;
  assign ex_instr8  = ex_r.instr8;
  assign ex_flag_wr = ex_r.flag_wr;
  assign ex_valid   = ex_valid_r;
  assign flag_n     = flag_out_s[2];
  assign flag_v     = flag_out_s[1];
  assign flag_z     = flag_out_s[0];
  assign halted     = halted_r;

endmodule

// File: tb/tb_ex_ctrl_decode.sv
// Bench for ex_ctrl_decode: directed scenarios followed by random traffic against a table-driven model.
module tb_ex_ctrl_decode;

  localparam logic [2:0] FLAG_RESET = 3'b000;
  localparam int         SHF_SETS_Z = 1;

  logic        clk = 1'b0;
  logic        rst_n, id_valid, stall, flush, alu_n, alu_v, alu_z;
  logic [15:0] id_instr;
  logic [1:0]  ex_alu_src, ex_shf_op;
  logic [2:0]  ex_alu_op, ex_flag_wr;
  logic        ex_llb, ex_lhb, ex_as, ex_valid, flag_n, flag_v, flag_z, halted;
  logic [7:0]  ex_instr8;

  int vectors = 0;
  int miscompares = 0;

  // Decode tables filled from the opcode rules
  logic [1:0] t_src [16];
  logic [2:0] t_op  [16];
  logic [1:0] t_shf [16];
  logic       t_llb [16];
  logic       t_lhb [16];
  logic       t_as  [16];
  logic [2:0] t_mask[16];

  // Model state
  logic [1:0] m_src, m_shf;
  logic [2:0] m_op, m_mask, m_flags;
  logic       m_llb, m_lhb, m_as, m_valid;
  logic [7:0] m_instr8;
  bit         m_halted;

  ex_ctrl_decode #(.FLAG_RESET(FLAG_RESET), .SHF_SETS_Z(SHF_SETS_Z)) dut (
    .clk(clk), .rst_n(rst_n), .id_instr(id_instr), .id_valid(id_valid),
    .stall(stall), .flush(flush), .alu_n(alu_n), .alu_v(alu_v), .alu_z(alu_z),
    .ex_alu_src(ex_alu_src), .ex_alu_op(ex_alu_op), .ex_shf_op(ex_shf_op),
    .ex_llb(ex_llb), .ex_lhb(ex_lhb), .ex_as(ex_as), .ex_instr8(ex_instr8),
    .ex_flag_wr(ex_flag_wr), .ex_valid(ex_valid), .flag_n(flag_n), .flag_v(flag_v),
    .flag_z(flag_z), .halted(halted)
  );

  always #5 clk = ~clk;

  task automatic init_tables();
    for (int i = 0; i < 16; i++) begin
      t_src[i] = 2'd0; t_op[i] = 3'd0; t_shf[i] = 2'd0;
      t_llb[i] = 1'b0; t_lhb[i] = 1'b0; t_as[i] = 1'b0; t_mask[i] = 3'd0;
    end
    for (int i = 0; i <= 4; i++) begin
      t_src[i]  = 2'd1;
      t_op[i]   = 3'(i);
      t_mask[i] = (i <= 2) ? 3'b111 : 3'b001;
    end
    for (int i = 5; i <= 7; i++) begin
      t_as[i]   = 1'b1;
      t_mask[i] = (SHF_SETS_Z != 0) ? 3'b001 : 3'b000;
    end
    t_shf[5] = 2'b00; t_shf[6] = 2'b11; t_shf[7] = 2'b01;
    t_src[8] = 2'd2;  t_src[9] = 2'd2;
    t_lhb[10] = 1'b1;
    t_as[11] = 1'b1;  t_llb[11] = 1'b1;
  endtask

  task automatic model_clear();
    m_src = 2'd0; m_op = 3'd0; m_shf = 2'd0; m_llb = 1'b0; m_lhb = 1'b0;
    m_as = 1'b0; m_instr8 = 8'd0; m_mask = 3'd0; m_valid = 1'b0;
  endtask

  // Apply one rising edge to the model using the current inputs
  task automatic model_edge();
    int opc;
    logic [2:0] alu_vec;
    alu_vec = {alu_n, alu_v, alu_z};
    if (!rst_n) begin
      model_clear();
      m_flags  = FLAG_RESET;
      m_halted = 1'b0;
    end else begin
      if (m_valid && !stall)
        for (int b = 0; b < 3; b++) if (m_mask[b]) m_flags[b] = alu_vec[b];
      if (flush) model_clear();
      else if (!stall) begin
        if (id_valid && !m_halted) begin
          opc = int'(id_instr[15:12]);
          m_src = t_src[opc]; m_op = t_op[opc]; m_shf = t_shf[opc];
          m_llb = t_llb[opc]; m_lhb = t_lhb[opc]; m_as = t_as[opc];
          m_mask = t_mask[opc]; m_instr8 = id_instr[7:0]; m_valid = 1'b1;
          if (opc == 15) m_halted = 1'b1;
        end else begin
          model_clear();
        end
      end
    end
  endtask

  function automatic logic [2:0] exp_flags();
    logic [2:0] f;
    f = m_flags;
`ifdef FLAG_BYPASS_EN
    if (m_valid && !stall) begin
      if (m_mask[2]) f[2] = alu_n;
      if (m_mask[1]) f[1] = alu_v;
      if (m_mask[0]) f[0] = alu_z;
    end
`endif
    return f;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic check_model();
    chk("ex_alu_src", 32'(ex_alu_src), 32'(m_src));
    chk("ex_alu_op",  32'(ex_alu_op),  32'(m_op));
    chk("ex_shf_op",  32'(ex_shf_op),  32'(m_shf));
    chk("ex_sel",     32'({ex_llb, ex_lhb, ex_as}), 32'({m_llb, m_lhb, m_as}));
    chk("ex_instr8",  32'(ex_instr8),  32'(m_instr8));
    chk("ex_flag_wr", 32'(ex_flag_wr), 32'(m_mask));
    chk("ex_valid",   32'(ex_valid),   32'(m_valid));
    chk("flags",      32'({flag_n, flag_v, flag_z}), 32'(exp_flags()));
    chk("halted",     32'(halted),     32'(m_halted));
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    check_model();
  endtask

  task automatic drive(input logic r, input logic v, input logic [15:0] ins,
                       input logic st, input logic fl, input logic [2:0] alu);
    rst_n = r; id_valid = v; id_instr = ins; stall = st; flush = fl;
    {alu_n, alu_v, alu_z} = alu;
  endtask

  initial begin
    init_tables();
    model_clear();
    m_flags = FLAG_RESET;
    m_halted = 1'b0;

    // Reset while stalled with a live instruction presented
    drive(1'b0, 1'b1, 16'h0123, 1'b1, 1'b0, 3'b111);
    step();
    chk("rst_ex_valid", 32'(ex_valid), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_flags", 32'({flag_n, flag_v, flag_z}), 32'(FLAG_RESET));

    // ADD then its flags
    drive(1'b1, 1'b1, 16'h0123, 1'b0, 1'b0, 3'b000);
    step();
    chk("add_src", 32'(ex_alu_src), 32'd1);
    chk("add_mask", 32'(ex_flag_wr), 32'd7);
    chk("add_instr8", 32'(ex_instr8), 32'h23);
    drive(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 3'b100);
    step();
`ifndef FLAG_BYPASS_EN
    chk("add_flags", 32'({flag_n, flag_v, flag_z}), 32'b100);
`endif

    // SUB sets V, then XOR touches only Z
    drive(1'b1, 1'b1, 16'h2000, 1'b0, 1'b0, 3'b000);
    step();
    drive(1'b1, 1'b1, 16'h4000, 1'b0, 1'b0, 3'b010);
    step();
    chk("xor_op", 32'(ex_alu_op), 32'd4);
    drive(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 3'b101);
    step();
`ifndef FLAG_BYPASS_EN
    chk("xor_flags", 32'({flag_n, flag_v, flag_z}), 32'b011);
`endif

    // SUB held by a 3-cycle stall, flags update once on release
    drive(1'b1, 1'b1, 16'h2345, 1'b0, 1'b0, 3'b000);
    step();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 16'h0123, 1'b1, 1'b0, 3'b111);
      step();
      chk("stall_op", 32'(ex_alu_op), 32'd2);
      chk("stall_instr8", 32'(ex_instr8), 32'h45);
    end
    drive(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 3'b111);
    step();
    chk("release_flags", 32'({flag_n, flag_v, flag_z}), 32'b111);
    drive(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 3'b000);
    step();
    chk("once_flags", 32'({flag_n, flag_v, flag_z}), 32'b111);

    // Flushed LLB, then a normal ADD
    drive(1'b1, 1'b1, 16'hB0A5, 1'b0, 1'b1, 3'b000);
    step();
    chk("flush_valid", 32'(ex_valid), 32'd0);
    chk("flush_llb", 32'(ex_llb), 32'd0);
    drive(1'b1, 1'b1, 16'h0123, 1'b0, 1'b0, 3'b000);
    step();
    chk("post_flush_valid", 32'(ex_valid), 32'd1);

    // HLT blocked by stall and by flush, then accepted
    drive(1'b1, 1'b1, 16'hF000, 1'b1, 1'b0, 3'b000);
    step();
    chk("hlt_stall", 32'(halted), 32'd0);
    drive(1'b1, 1'b1, 16'hF000, 1'b0, 1'b1, 3'b000);
    step();
    chk("hlt_flush", 32'(halted), 32'd0);
    drive(1'b1, 1'b1, 16'hF000, 1'b0, 1'b0, 3'b000);
    step();
    chk("hlt_halted", 32'(halted), 32'd1);
    chk("hlt_valid", 32'(ex_valid), 32'd1);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 16'h0123, 1'b0, 1'b0, 3'b111);
      step();
      chk("halted_bubble", 32'(ex_valid), 32'd0);
    end
    drive(1'b0, 1'b1, 16'h0123, 1'b0, 1'b0, 3'b000);
    step();
    chk("halt_reset", 32'(halted), 32'd0);

    // Random traffic
    for (int i = 0; i < 800; i++) begin
      drive(1'($urandom_range(0, 49) != 0), 1'($urandom_range(0, 3) != 0),
            16'($urandom), 1'($urandom_range(0, 4) == 0),
            1'($urandom_range(0, 7) == 0), 3'($urandom));
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
